vga_timing_gen: RTL

//   Raster timing generator for the VGA output path. It produces the pixel coordinates
//   (x, y) and the pixel_on flag that the colour-generation logic consumes. It also

---
 rtl/vga_timing_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: divides clk into pixel ticks and walks x/y over the frame, emitting registered
// coordinates, pixel_on, syncs and strobes one tick behind the counters. Free-running; no backpressure.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CLK_DIV  = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixel_on,
   output logic       hsync,
   output logic       vsync,
   output logic       pix_tick,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_params
         $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
      end
   endgenerate

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_cnt;
   logic [9:0]    h_cnt;
   logic [9:0]    v_cnt;
   logic          tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   // Output stage samples the pre-increment counters, so everything lands one tick behind them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         pixel_on    <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         pix_tick    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_tick    <= tick;
         frame_start <= tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
         if (tick) begin
            x        <= h_cnt;
            y        <= v_cnt;
            pixel_on <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hsync    <= (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync    <= (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

endmodule
